mem_arbiter: RTL and testbench

Two-port arbiter sharing one main-memory block port between the instruction-cache refill path and the data-cache refill/write-back path. It sits between both caches and the unified memory model: it accepts level-held busywait-style requests, serialises them with round-robin priority, drives the single memory port, and returns the fetched block to the winning cache.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/rr_pick2.sv | 24 ++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

    // Default block address width (tag+index) and block data width.
    localparam int MEM_ADDR_W  = 6;
    localparam int MEM_BLOCK_W = 128;

    // Arbiter sequencing states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_ISSUE = 3'd1,
        I_WAIT  = 3'd2,
        I_DONE  = 3'd3,
        D_ISSUE = 3'd4,
        D_WAIT  = 3'd5,
        D_DONE  = 3'd6
    } state_t;

    // Grant-port encoding, also used for the last-grant history bit.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin select: a lone requester wins; on a tie the port
// that was not granted last time wins.
import mem_arb_pkg::*;

module rr_pick2 (
    input  logic  req_i,
    input  logic  req_d,
    input  port_t last_grant,
    output logic  grant_valid,
    output port_t grant
);

    // Combinational pick between the two pending bits.
    always_comb begin
        grant_valid = req_i | req_d;
        grant       = PORT_I;
        if (req_i && req_d) begin
            grant = (last_grant == PORT_D) ? PORT_I : PORT_D;
        end else if (req_d) begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one block-wide memory port between the icache refill
// path and the dcache refill/write-back path. Requests are level-held
// busywait style; the winner's address/operation are latched at grant
// and the fetched block is returned on the matching readdata output.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int BLOCK_W = MEM_BLOCK_W
) (
    input  logic               clock,
    input  logic               reset,
    // icache side
    input  logic               i_read,
    input  logic [ADDR_W-1:0]  i_address,
    output logic [BLOCK_W-1:0] i_readdata,
    output logic               i_busywait,
    // dcache side
    input  logic               d_read,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_address,
    input  logic [BLOCK_W-1:0] d_writedata,
    output logic [BLOCK_W-1:0] d_readdata,
    output logic               d_busywait,
    // memory side
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_writedata,
    input  logic [BLOCK_W-1:0] mem_readdata,
    input  logic               mem_busywait
);

    state_t               state_q, state_d;
    port_t                last_grant_q, last_grant_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]    mem_address_q, mem_address_d;
    logic [BLOCK_W-1:0]   mem_writedata_q, mem_writedata_d;
    logic [BLOCK_W-1:0]   i_readdata_q, i_readdata_d;
    logic [BLOCK_W-1:0]   d_readdata_q, d_readdata_d;

    logic                 d_pending;
    logic                 grant_valid;
    port_t                grant;

    assign d_pending = d_read | d_write;

    rr_pick2 u_pick (
        .req_i       (i_read),
        .req_d       (d_pending),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Next-state and next-output computation for the arbiter sequence.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        i_readdata_d    = i_readdata_q;
        d_readdata_d    = d_readdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    last_grant_d = grant;
                    if (grant == PORT_I) begin
                        state_d       = I_ISSUE;
                        mem_address_d = i_address;
                        mem_read_d    = 1'b1;
                        mem_write_d   = 1'b0;
                    end else begin
                        state_d       = D_ISSUE;
                        mem_address_d = d_address;
                        // A simultaneous read+write request is treated as a write.
                        if (d_write) begin
                            mem_read_d      = 1'b0;
                            mem_write_d     = 1'b1;
                            mem_writedata_d = d_writedata;
                        end else begin
                            mem_read_d      = 1'b1;
                            mem_write_d     = 1'b0;
                        end
                    end
                end
            end
            // Memory gets one full cycle to raise busywait before it is sampled.
            I_ISSUE: state_d = I_WAIT;
            D_ISSUE: state_d = D_WAIT;
            I_WAIT: begin
                if (!mem_busywait) begin
                    state_d      = I_DONE;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    i_readdata_d = mem_readdata;
                end
            end
            D_WAIT: begin
                if (!mem_busywait) begin
                    state_d     = D_DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    // The latched strobe tells whether this was a refill.
                    if (mem_read_q) begin
                        d_readdata_d = mem_readdata;
                    end
                end
            end
            I_DONE:  state_d = IDLE;
            D_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any transaction at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            last_grant_q    <= PORT_D;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            i_readdata_q    <= '0;
            d_readdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            i_readdata_q    <= i_readdata_d;
            d_readdata_q    <= d_readdata_d;
        end
    end

    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign i_readdata    = i_readdata_q;
    assign d_readdata    = d_readdata_q;

    // Requesters are released only during their own DONE cycle.
    assign i_busywait = i_read    & (state_q != I_DONE);
    assign d_busywait = d_pending & (state_q != D_DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-programmable memory.
module tb_mem_arbiter;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         i_read = 1'b0;
    logic [5:0]   i_address = '0;
    logic [127:0] i_readdata;
    logic         i_busywait;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [5:0]   d_address = '0;
    logic [127:0] d_writedata = '0;
    logic [127:0] d_readdata;
    logic         d_busywait;
    logic         mem_read;
    logic         mem_write;
    logic [5:0]   mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata = '0;
    logic         mem_busywait;

    int tests = 0;
    int fails = 0;

    // memory model: busywait high for mem_lat sampled edges after the issue edge
    int           mem_lat = 0;
    int           busy_cnt = 0;
    int           read_cnt = 0;
    logic [127:0] last_wdata = '0;
    logic [5:0]   last_waddr = '0;

    localparam logic [127:0] DATA1 = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] DATA2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] DATA3 = 128'hCAFE_F00D_0BAD_BEEF_0000_1234_5678_9ABC;
    localparam logic [127:0] DATA4 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] WB_A5 = {16{8'hA5}};
    localparam logic [127:0] WB_5A = {16{8'h5A}};

    always #5 clock = ~clock;

    assign mem_busywait = (mem_read | mem_write) && (busy_cnt < mem_lat + 1);

    always @(posedge clock) begin
        if (!(mem_read | mem_write)) busy_cnt <= 0;
        else                         busy_cnt <= busy_cnt + 1;
        if (mem_read) read_cnt <= read_cnt + 1;
        if (mem_write && !mem_busywait) begin
            last_wdata <= mem_writedata;
            last_waddr <= mem_address;
        end
    end

    mem_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_busywait    (i_busywait),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_readdata    (d_readdata),
        .d_busywait    (d_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // called at the first negedge after the grant edge; k=1 there
    task automatic wait_rel(input logic which_d, input int max, output int k);
        k = 1;
        while (((which_d ? d_busywait : i_busywait) === 1'b1) && k < max) begin
            @(negedge clock);
            k++;
        end
    endtask

    initial begin
        int k;
        int rc;

        // ---- reset state
        @(negedge clock);
        chk("rst_mem_read",   {127'd0, mem_read},  128'd0);
        chk("rst_mem_write",  {127'd0, mem_write}, 128'd0);
        chk("rst_mem_addr",   {122'd0, mem_address}, 128'd0);
        chk("rst_i_readdata", i_readdata, 128'd0);
        chk("rst_d_readdata", d_readdata, 128'd0);
        chk("rst_busywaits",  {126'd0, i_busywait, d_busywait}, 128'd0);
        reset = 1'b0;
        @(negedge clock);

        // ---- I only, 5 busy cycles: DONE at e7, seen at negedge 8
        mem_lat = 5; mem_readdata = DATA1;
        i_address = 6'h2A; i_read = 1'b1;
        @(negedge clock);
        chk("i_issue_read", {127'd0, mem_read}, 128'd1);
        chk("i_issue_addr", {122'd0, mem_address}, 128'h2A);
        wait_rel(1'b0, 40, k);
        chk("i_release_cycle", k, 8);
        chk("i_readdata", i_readdata, DATA1);
        chk("i_strobe_drop", {127'd0, mem_read}, 128'd0);
        i_read = 1'b0;
        @(negedge clock);

        // ---- D write-back, 2 busy cycles
        mem_lat = 2; rc = read_cnt;
        d_address = 6'h05; d_writedata = WB_A5; d_write = 1'b1;
        @(negedge clock);
        chk("d_wb_write", {127'd0, mem_write}, 128'd1);
        chk("d_wb_wdata", mem_writedata, WB_A5);
        chk("d_wb_addr", {122'd0, mem_address}, 128'h05);
        wait_rel(1'b1, 40, k);
        chk("d_wb_release_cycle", k, 5);
        chk("d_wb_mem_wdata", last_wdata, WB_A5);
        chk("d_wb_no_read", read_cnt - rc, 0);
        d_write = 1'b0;
        @(negedge clock);

        // ---- simultaneous requests after reset: I, then D, then I again
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mem_lat = 0; mem_readdata = DATA2;
        i_address = 6'h11; d_address = 6'h22;
        i_read = 1'b1; d_read = 1'b1;
        @(negedge clock);
        chk("tie1_addr_i", {122'd0, mem_address}, 128'h11);
        chk("tie1_d_stalled", {127'd0, d_busywait}, 128'd1);
        wait_rel(1'b0, 20, k);
        chk("tie1_i_release", k, 3);
        chk("tie1_i_data", i_readdata, DATA2);
        i_read = 1'b0; i_address = 6'h33;
        @(negedge clock);
        i_read = 1'b1;
        @(negedge clock);
        chk("tie2_addr_d", {122'd0, mem_address}, 128'h22);
        chk("tie2_i_stalled", {127'd0, i_busywait}, 128'd1);
        wait_rel(1'b1, 20, k);
        chk("tie2_d_release", k, 3);
        chk("tie2_d_data", d_readdata, DATA2);
        d_read = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("tie2_addr_i", {122'd0, mem_address}, 128'h33);
        wait_rel(1'b0, 20, k);
        chk("tie2_i_release", k, 3);
        i_read = 1'b0;
        @(negedge clock);

        // ---- d_read and d_write both high: write wins
        mem_lat = 1; rc = read_cnt;
        d_address = 6'h0C; d_writedata = WB_5A;
        d_read = 1'b1; d_write = 1'b1;
        @(negedge clock);
        chk("rw_write", {127'd0, mem_write}, 128'd1);
        chk("rw_no_read", {127'd0, mem_read}, 128'd0);
        wait_rel(1'b1, 20, k);
        chk("rw_release", k, 4);
        chk("rw_mem_addr", {122'd0, last_waddr}, 128'h0C);
        chk("rw_mem_wdata", last_wdata, WB_5A);
        chk("rw_read_cnt", read_cnt - rc, 0);
        chk("rw_d_readdata_held", d_readdata, DATA2);
        d_read = 1'b0; d_write = 1'b0;
        @(negedge clock);

        // ---- zero-wait I: released exactly one cycle (e2-e3)
        mem_lat = 0; mem_readdata = DATA3;
        i_address = 6'h3F; i_read = 1'b1;
        @(negedge clock);
        wait_rel(1'b0, 20, k);
        chk("zw_release", k, 3);
        chk("zw_data", i_readdata, DATA3);
        @(negedge clock);
        chk("zw_stall_again", {127'd0, i_busywait}, 128'd1);
        i_read = 1'b0;
        @(negedge clock);

        // ---- reset during D_WAIT
        mem_lat = 10;
        d_address = 6'h07; d_writedata = WB_A5; d_write = 1'b1;
        @(negedge clock);
        chk("rstw_write", {127'd0, mem_write}, 128'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rstw_write_drop", {127'd0, mem_write}, 128'd0);
        chk("rstw_d_readdata", d_readdata, 128'd0);
        chk("rstw_wdata", mem_writedata, 128'd0);
        d_write = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        mem_lat = 0; mem_readdata = DATA4;
        i_address = 6'h15; i_read = 1'b1;
        @(negedge clock);
        chk("post_rst_addr", {122'd0, mem_address}, 128'h15);
        wait_rel(1'b0, 20, k);
        chk("post_rst_release", k, 3);
        chk("post_rst_data", i_readdata, DATA4);
        i_read = 1'b0;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // global watchdog
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
